// File: rtl/ahb_sub_mem.sv
// AHB-Lite subordinate backed by a word-organised on-chip memory.
// OKAY transfers take WAIT_STATES extra cycles; errors always take two cycles (ERR1, ERR2).
module ahb_sub_mem #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK_i,
   input  logic                  HRESET_i,
   input  logic                  HSEL_i,
   input  logic [ADDR_WIDTH-1:0] HADDR_i,
   input  logic [1:0]            HTRANS_i,
   input  logic                  HWRITE_i,
   input  logic [2:0]            HSIZE_i,
   input  logic [DATA_WIDTH-1:0] HWDATA_i,
   input  logic                  HREADY_i,
   output logic                  HREADYOUT_o,
   output logic [1:0]            HRESP_o,
   output logic [DATA_WIDTH-1:0] HRDATA_o
);
   localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int NB = DATA_WIDTH / 8;
   localparam logic [1:0] OKAY  = 2'b00;
   localparam logic [1:0] ERROR = 2'b01;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            vld_q, vld_d;
   logic            wr_q, wr_d;
   logic [2:0]      size_q, size_d;
   logic [1:0]      off_q, off_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            accept, err, complete;
   logic [NB-1:0]   be;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic            unused_ok;

   assign unused_ok = HTRANS_i[0];
   assign accept    = HSEL_i & HREADY_i & HTRANS_i[1];

   always_comb begin
      err = 1'b0;
      if ({2'b00, HADDR_i[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_DEPTH)) err = 1'b1;
      if (HSIZE_i > 3'b010) err = 1'b1;
      if (HSIZE_i == 3'b001 && HADDR_i[0]) err = 1'b1;
      if (HSIZE_i == 3'b010 && HADDR_i[1:0] != 2'b00) err = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      vld_d       = vld_q;
      wr_d        = wr_q;
      size_d      = size_q;
      off_d       = off_q;
      idx_d       = idx_q;
      HREADYOUT_o = 1'b1;
      HRESP_o     = OKAY;
      case (state_q)
         S_WAIT: begin
            HREADYOUT_o = 1'b0;
            if (cnt_q == 4'd0) state_d = S_IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ERR1: begin
            HREADYOUT_o = 1'b0;
            HRESP_o     = ERROR;
            state_d     = S_ERR2;
         end
         S_ERR2: begin
            HRESP_o = ERROR;
            state_d = S_IDLE;
         end
         default: ;
      endcase
      // ERR2 ends the errored data phase, so it can take a new address phase like IDLE
      if ((state_q == S_IDLE || state_q == S_ERR2) && HREADY_i) begin
         vld_d = accept & ~err;
         if (accept) begin
            wr_d   = HWRITE_i;
            size_d = HSIZE_i;
            off_d  = HADDR_i[1:0];
            idx_d  = HADDR_i[IW+1:2];
            if (err)                  state_d = S_ERR1;
            else if (WAIT_STATES > 0) begin
               state_d = S_WAIT;
               cnt_d   = 4'(WAIT_STATES - 1);
            end else                  state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge HCLK_i or posedge HRESET_i) begin
      if (HRESET_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         wr_q    <= 1'b0;
         size_q  <= '0;
         off_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         off_q   <= off_d;
         idx_q   <= idx_d;
      end
   end

   assign complete = HREADYOUT_o & vld_q;

   always_comb begin
      be = '0;
      case (size_q)
         3'b000:  be[off_q] = 1'b1;
         3'b001:  be[{off_q[1], 1'b0} +: 2] = 2'b11;
         default: be = '1;
      endcase
   end

   // vld_q is cleared asynchronously, so a reset mid-transfer drops the pending write
   always_ff @(posedge HCLK_i) begin
      if (complete && wr_q) begin
         for (int b = 0; b < NB; b++)
            if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA_i[8*b +: 8];
      end
   end

   assign HRDATA_o = (complete && !wr_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_sub_mem.sv
// Bench for ahb_sub_mem: two instances (0 and 3 wait states) driven by a pipelined
// AHB driver and checked cycle by cycle against a byte-lane memory model.
module tb_ahb_sub_mem;
   typedef struct {
      bit        sel;
      bit [1:0]  trans;
      bit        wr;
      bit [2:0]  size;
      bit [31:0] addr;
      bit [31:0] wdata;
   } xfer_t;

   logic        clk, rst, hsel, hwrite, stall, dsel;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        ro0, ro3;
   logic [1:0]  rs0, rs3;
   logic [31:0] rd0, rd3;

   int nvec = 0;
   int nmis = 0;
   bit [31:0] refm [2][256];

   ahb_sub_mem #(.WAIT_STATES(0)) dut0 (
      .HCLK_i(clk), .HRESET_i(rst), .HSEL_i(hsel & ~dsel), .HADDR_i(haddr),
      .HTRANS_i(htrans), .HWRITE_i(hwrite), .HSIZE_i(hsize), .HWDATA_i(hwdata),
      .HREADY_i(ro0 & ~stall), .HREADYOUT_o(ro0), .HRESP_o(rs0), .HRDATA_o(rd0));

   ahb_sub_mem #(.WAIT_STATES(3)) dut3 (
      .HCLK_i(clk), .HRESET_i(rst), .HSEL_i(hsel & dsel), .HADDR_i(haddr),
      .HTRANS_i(htrans), .HWRITE_i(hwrite), .HSIZE_i(hsize), .HWDATA_i(hwdata),
      .HREADY_i(ro3 & ~stall), .HREADYOUT_o(ro3), .HRESP_o(rs3), .HRDATA_o(rd3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic xfer_t mk(bit sel, bit [1:0] trans, bit wr, bit [2:0] size,
                                bit [31:0] addr, bit [31:0] wdata);
      xfer_t x;
      x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
      return x;
   endfunction

   function automatic bit is_err(xfer_t x);
      return (x.addr[31:2] >= 256) || (x.size > 2) ||
             (x.size == 1 && x.addr[0]) || (x.size == 2 && x.addr[1:0] != 0);
   endfunction

   task automatic mwrite(input int d, input xfer_t x);
      int off = int'(x.addr[1:0]);
      int n   = 1 << x.size;
      for (int b = 0; b < n; b++)
         refm[d][x.addr[9:2]][8*(off+b) +: 8] = x.wdata[8*(off+b) +: 8];
   endtask

   task automatic idle_bus();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b000; haddr = '0;
   endtask

   // Pipelined manager: the address phase of the next item overlaps the data phase of the current one.
   task automatic run(input int d, input xfer_t q[$]);
      xfer_t cur;
      bit    cur_v = 0, e = 0, exp_r;
      int    ph = 0, i = 0, guard = 0;
      int    ws = (d == 1) ? 3 : 0;
      logic  rdy; logic [1:0] rsp; logic [31:0] rdat;
      dsel = (d == 1);
      while ((i < q.size() || cur_v) && guard < 4000) begin
         @(negedge clk);
         guard++;
         if (cur_v) hwdata = cur.wdata;
         rdy  = d ? ro3 : ro0;
         rsp  = d ? rs3 : rs0;
         rdat = d ? rd3 : rd0;
         if (!cur_v) begin
            chk("idle_ready", rdy, 1);
            chk("idle_resp", rsp, 0);
            chk("idle_rdata", rdat, 0);
         end else begin
            e     = is_err(cur);
            exp_r = e ? (ph == 1) : (ph == ws);
            chk(e ? "err_ready" : "ok_ready", rdy, exp_r);
            chk(e ? "err_resp" : "ok_resp", rsp, e ? 2'b01 : 2'b00);
            if (exp_r && !e) chk("rdata", rdat, cur.wr ? 32'h0 : refm[d][cur.addr[9:2]]);
            ph++;
         end
         if (rdy) begin
            if (cur_v && !e && cur.wr) mwrite(d, cur);
            cur_v = 0;
            if (i < q.size()) begin
               hsel = q[i].sel; htrans = q[i].trans; hwrite = q[i].wr;
               hsize = q[i].size; haddr = q[i].addr;
               if (q[i].sel && q[i].trans[1]) begin
                  cur = q[i]; cur_v = 1; ph = 0;
               end
               i++;
            end else idle_bus();
         end
      end
      if (guard >= 4000) chk("timeout", 1, 0);
   endtask

   initial begin
      xfer_t q[$];
      rst = 1'b1; stall = 1'b0; dsel = 1'b0; hwdata = '0;
      idle_bus();
      repeat (3) @(negedge clk);
      chk("rst_ready3", ro3, 1);
      chk("rst_resp0", rs0, 0);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("reset_ready0", ro0, 1); chk("reset_resp0", rs0, 0); chk("reset_rdata0", rd0, 0);
         chk("reset_ready3", ro3, 1); chk("reset_resp3", rs3, 0); chk("reset_rdata3", rd3, 0);
      end

      for (int d = 0; d < 2; d++) begin
         q.delete();
         for (int w = 0; w < 16; w++) q.push_back(mk(1, 2'b10, 1, 3'd2, 32'(4*w), $urandom));
         q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF));
         q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h10, 32'h0));
         q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h10, 32'h11223344));
         q.push_back(mk(1, 2'b10, 1, 3'd0, 32'h12, 32'h000000AA));
         q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h10, 32'h0));
         q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h02, 32'h0));
         q.push_back(mk(1, 2'b10, 1, 3'd2, 32'h400, 32'hFFFFFFFF));
         q.push_back(mk(1, 2'b11, 0, 3'd2, 32'h0, 32'h0));
         q.push_back(mk(1, 2'b10, 1, 3'd1, 32'h21, 32'h12345678));
         q.push_back(mk(1, 2'b10, 1, 3'd3, 32'h20, 32'h12345678));
         q.push_back(mk(1, 2'b00, 1, 3'd2, 32'h20, 32'h0));
         q.push_back(mk(1, 2'b01, 1, 3'd2, 32'h24, 32'h0));
         q.push_back(mk(0, 2'b10, 1, 3'd2, 32'h28, 32'h0));
         q.push_back(mk(1, 2'b10, 1, 3'd1, 32'h22, 32'h0000BEEF));
         q.push_back(mk(1, 2'b11, 0, 3'd2, 32'h20, 32'h0));
         q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h3FC, 32'h0));
         run(d, q);
      end

      // address phase presented while HREADY is low must be ignored
      dsel = 1'b0;
      @(negedge clk);
      stall = 1'b1; hsel = 1'b1; htrans = 2'b10; hsize = 3'd2; haddr = 32'h2; hwrite = 1'b0;
      @(negedge clk);
      stall = 1'b0; idle_bus();
      chk("stall_ready", ro0, 1); chk("stall_resp", rs0, 0);
      @(negedge clk);
      chk("stall_ready2", ro0, 1); chk("stall_resp2", rs0, 0);

      // reset during a waited write aborts it
      dsel = 1'b1;
      @(negedge clk);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
      @(negedge clk);
      idle_bus(); hwdata = 32'hCAFEF00D;
      chk("abort_wait", ro3, 0);
      @(negedge clk);
      chk("abort_wait2", ro3, 0);
      rst = 1'b1;
      #1;
      chk("abort_ready", ro3, 1); chk("abort_resp", rs3, 0); chk("abort_rdata", rd3, 0);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      q.push_back(mk(1, 2'b10, 0, 3'd2, 32'h10, 32'h0));
      run(1, q);

      for (int d = 0; d < 2; d++) begin
         q.delete();
         for (int k = 0; k < 80; k++) begin
            xfer_t x;
            x.sel   = ($urandom_range(0, 7) != 0);
            x.trans = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            x.wr    = 1'($urandom_range(0, 1));
            x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            x.addr  = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                                   : 32'($urandom_range(0, 63));
            x.wdata = $urandom;
            q.push_back(x);
         end
         run(d, q);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
